sram_access_controller: RTL and testbench

- Initiator for the single-port synchronous SRAM port (select / read_not_write / write_enable / address / write_data, registered data_out).
- Accepts read and write requests from a client over a valid/ready handshake and issues at most one SRAM access per cycle, in order.
- Captures SRAM read data in the exact cycle it becomes valid and returns it through a response FIFO with valid/ready backpressure.
- Sits between bus or DMA logic and any 2^ADDR_WIDTH x DATA_WIDTH synchronous SRAM in the design.

---
 rtl/sram_access_controller.sv | 136 +++++++++++++
 tb/tb_sram_access_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_controller.sv
// In-order initiator for a single-port synchronous SRAM. It issues at most one access per cycle.
// Read data is returned through a response FIFO that is protected by a credit count.
module sram_access_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  sram_clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  idle,
  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic                  sram_write_enable,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  logic                  sel_q, sel_d;
  logic                  rnw_q, rnw_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  capture_q, capture_d;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

  logic                  issue_rd;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CRD_W-1:0]      credits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every read that has been accepted and not yet popped holds one FIFO slot.
  // This guarantees that a capture always has room in the FIFO.
  assign issue_rd  = sel_q & rnw_q;
  assign credits   = CRD_W'(count_q) + CRD_W'(issue_rd) + CRD_W'(capture_q);
  assign req_ready = credits < CRD_W'(RSP_DEPTH);
  assign accept    = req_valid & req_ready;

  assign push      = capture_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? mem[rd_ptr_q] : last_q;
  assign idle      = !sel_q && !capture_q && (count_q == '0);

  assign sram_select         = sel_q;
  assign sram_read_not_write = rnw_q;
  assign sram_write_enable   = we_q;
  assign sram_address        = addr_q;
  assign sram_write_data     = wdata_q;

  always_comb begin
    sel_d     = 1'b0;
    rnw_d     = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    capture_d = issue_rd;
    if (accept) begin
      sel_d  = 1'b1;
      rnw_d  = !req_write;
      we_d   = req_write;
      addr_d = req_address;
      if (req_write) begin
        wdata_d = req_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    last_d   = pop  ? mem[rd_ptr_q]     : last_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= 1'b0;
      rnw_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      capture_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= '0;
    end else begin
      sel_q     <= sel_d;
      rnw_q     <= rnw_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      capture_q <= capture_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
    end
  end

  // sram_data_out is valid only in the cycle while capture_q is set.
  always_ff @(posedge sram_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= sram_data_out;
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller. It drives a behavioural SRAM and checks the DUT every cycle
// against a transaction-level model: a memory map plus a queue of outstanding reads.
module tb_sram_access_controller;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          idle;
  logic          sram_select, sram_rnw, sram_we;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_wdata, sram_dout;

  always #5 clk = ~clk;

  sram_access_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .sram_clock         (clk),
    .reset_n            (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_address        (req_address),
    .req_data           (req_data),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .idle               (idle),
    .sram_select        (sram_select),
    .sram_read_not_write(sram_rnw),
    .sram_write_enable  (sram_we),
    .sram_address       (sram_address),
    .sram_write_data    (sram_wdata),
    .sram_data_out      (sram_dout)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hFF;
  endfunction

  // Behavioural SRAM: registered read data, and noise whenever no read was sampled.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  bit            sram_wr  [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_select && sram_we) begin
      sram_mem[sram_address] <= sram_wdata;
      sram_wr[sram_address]  <= 1'b1;
    end
    if (sram_select && sram_rnw)
      sram_dout <= sram_wr[sram_address] ? sram_mem[sram_address] : init_val(sram_address);
    else
      sram_dout <= DW'($urandom);
  end

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] want;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
    bit            has_tab;
    logic [DW-1:0] tab;
  } rd_t;

  vec_t          tab[$];
  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem [int];

  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            we_cycles, first_rv, dut_acc, stalls, last_rd_acc_edge;
  bit            prev_acc, prev_wr, cur_has_tab;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, last_pop, cur_tab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic reset_model();
    exp_q.delete();
    prev_acc  = 1'b0;
    prev_wr   = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    last_pop  = '0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sram_select"}, 32'(sram_select), 32'(0));
    check({tag, "_sram_rnw"},    32'(sram_rnw),    32'(0));
    check({tag, "_sram_we"},     32'(sram_we),     32'(0));
    check({tag, "_sram_addr"},   32'(sram_address), 32'(0));
    check({tag, "_sram_wdata"},  32'(sram_wdata),  32'(0));
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'(0));
    check({tag, "_rsp_data"},    32'(rsp_data),    32'(0));
    check({tag, "_idle"},        32'(idle),        32'(1));
  endtask

  // Called just after a falling edge, once the inputs are set. It checks the outputs,
  // advances the model for the coming rising edge, and returns at the next falling edge.
  task automatic cycle(output bit acc);
    bit  pop, rv_exp;
    rd_t e;
    #1;
    rv_exp = (exp_q.size() > 0) && (cyc >= exp_q[0].avail);
    if (sram_we) we_cycles++;
    if (rsp_valid && first_rv < 0) first_rv = cyc;
    if (req_valid && req_ready) dut_acc++;
    check("req_ready",  32'(req_ready), 32'(exp_q.size() < DEPTH));
    check("idle",       32'(idle),      32'(!prev_acc && exp_q.size() == 0));
    check("rsp_valid",  32'(rsp_valid), 32'(rv_exp));
    check("rsp_data",   32'(rsp_data),  rv_exp ? 32'(exp_q[0].data) : 32'(last_pop));
    check("sram_select",         32'(sram_select),  32'(prev_acc));
    check("sram_write_enable",   32'(sram_we),      32'(prev_acc && prev_wr));
    check("sram_read_not_write", 32'(sram_rnw),     32'(prev_acc && !prev_wr));
    check("sram_address",        32'(sram_address), 32'(exp_addr));
    check("sram_write_data",     32'(sram_wdata),   32'(exp_wdata));
    acc = req_valid && (exp_q.size() < DEPTH);
    pop = rsp_ready && rv_exp;
    if (pop) begin
      e = exp_q.pop_front();
      last_pop = e.data;
      if (e.has_tab) check("table_rsp", 32'(rsp_data), 32'(e.tab));
    end
    prev_acc = acc;
    if (acc) begin
      prev_wr  = req_write;
      exp_addr = req_address;
      if (req_write) begin
        exp_wdata = req_data;
        ref_mem[int'(req_address)] = req_data;
      end else begin
        e.data    = ref_rd(req_address);
        e.avail   = cyc + 3;
        e.has_tab = cur_has_tab;
        e.tab     = cur_tab;
        exp_q.push_back(e);
        last_rd_acc_edge = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int g = 0;
    req_valid   = 1'b0;
    cur_has_tab = 1'b0;
    rsp_ready   = 1'b1;
    while ((exp_q.size() > 0 || prev_acc) && g < 100) begin
      cycle(acc);
      g++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'(0));
    cycle(acc);
  endtask

  task automatic add(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] w);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.want = w;
    tab.push_back(v);
  endtask

  // Streams the table back-to-back. rsp_ready is held low for the first 'hold' cycles.
  task automatic stream(input int hold);
    bit acc;
    int i = 0;
    int k = 0;
    int acc_base = dut_acc;
    while (i < tab.size() && k < 400) begin
      if (hold > 0 && k == hold) begin
        check("accepts_while_blocked", 32'(dut_acc - acc_base), 32'(DEPTH));
        check("req_ready_when_full",   32'(req_ready),          32'(0));
      end
      rsp_ready   = (k >= hold);
      req_valid   = 1'b1;
      req_write   = tab[i].wr;
      req_address = tab[i].addr;
      req_data    = tab[i].data;
      cur_has_tab = !tab[i].wr;
      cur_tab     = tab[i].want;
      cycle(acc);
      if (acc) i++;
      else stalls++;
      k++;
    end
    check("stream_complete", 32'(i), 32'(tab.size()));
    drain();
    tab.delete();
  endtask

  initial begin
    bit acc;
    int mode;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    rsp_ready = 1'b0; cur_has_tab = 1'b0; cur_tab = '0;
    we_cycles = 0; first_rv = -1; dut_acc = 0; stalls = 0; last_rd_acc_edge = 0;
    reset_model();
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;

    // Write followed by a read of the same address in the next cycle.
    add(1'b1, 16'h1234, 8'h5A, 8'h00);
    add(1'b0, 16'h1234, 8'h00, 8'h5A);
    we_cycles = 0;
    first_rv  = -1;
    stream(0);
    check("we_one_cycle", 32'(we_cycles), 32'(1));
    check("rd_latency",   32'(first_rv - last_rd_acc_edge), 32'(2));

    // 16 back-to-back reads with rsp_ready held high.
    for (int i = 0; i < 16; i++) add(1'b0, AW'(i), 8'h00, 8'(8'hFF - i));
    stalls = 0;
    stream(0);
    check("no_stall_streaming", 32'(stalls), 32'(0));

    // The same reads with the response side blocked for the first 10 cycles.
    for (int i = 0; i < 16; i++) add(1'b0, AW'(i), 8'h00, 8'(8'hFF - i));
    stream(10);

    // Top and bottom of the address space must not alias.
    add(1'b1, 16'hFFFF, 8'hAA, 8'h00);
    add(1'b1, 16'h0000, 8'h55, 8'h00);
    add(1'b0, 16'hFFFF, 8'h00, 8'hAA);
    add(1'b0, 16'h0000, 8'h00, 8'h55);
    stream(0);

    // Reset asserted in the middle of a read burst with responses backed up.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_address = AW'(i + 2);
      cycle(acc);
    end
    check("pre_reset_select", 32'(sram_select), 32'(1));
    rst_n = 1'b0;
    #1;
    reset_checks("async");
    reset_model();
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(acc);

    // Random traffic over a small address window, with rsp_ready varying between phases.
    mode = 0;
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) mode = int'($urandom_range(0, 2));
      req_valid   = ($urandom_range(0, 9) < 7);
      req_write   = 1'($urandom_range(0, 1));
      req_address = AW'($urandom_range(0, 15)) | ((n % 7 == 0) ? 16'hFFF0 : 16'h0000);
      req_data    = DW'($urandom);
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) == 0);
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      cycle(acc);
    end
    drain();
    check("final_idle", 32'(idle), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
